// File: rtl/conv3x3_mac_if.sv
// Window/result bundle between the window buffer and the 3x3 MAC.
// master: drives start and the nine window pixels, observes the result.
// slave:  the MAC engine itself.
interface conv3x3_mac_if #(
  parameter int PW = 9
);
  logic          start;
  logic [PW-1:0] m1d1, m1d2, m1d3;
  logic [PW-1:0] m2d1, m2d2, m2d3;
  logic [PW-1:0] m3d1, m3d2, m3d3;
  logic          busy;
  logic [PW-1:0] pix_out;
  logic          done;
  logic [15:0]   pix_count;
  logic          frame_done;

  modport master (
    output start, m1d1, m1d2, m1d3, m2d1, m2d2, m2d3, m3d1, m3d2, m3d3,
    input  busy, pix_out, done, pix_count, frame_done
  );

  modport slave (
    input  start, m1d1, m1d2, m1d3, m2d1, m2d2, m2d3, m3d1, m3d2, m3d3,
    output busy, pix_out, done, pix_count, frame_done
  );
endinterface

// File: rtl/conv3x3_mac.sv
// Serial 3x3 kernel MAC: latches a window, runs 9 MAC cycles on one
// multiplier, normalises by right shift, saturates to PW bits and emits
// one pixel with a done pulse. Counts results per frame.
// Optional build macro CONV_ABS_OUT_EN: output |acc| >> SHIFT instead of
// clamping negative sums to zero (for edge kernels).
//
// state | meaning
// IDLE  | waiting for start; window latched on the start edge
// MAC   | one kernel tap per cycle, idx 0..8
// NORM  | shift, saturate, write pix_out, pulse done
module conv3x3_mac #(
  parameter int PW        = 9,
  parameter int CW        = 5,
  parameter int ACC_W     = 18,
  parameter int K0        = 1,
  parameter int K1        = 2,
  parameter int K2        = 1,
  parameter int K3        = 2,
  parameter int K4        = 4,
  parameter int K5        = 2,
  parameter int K6        = 1,
  parameter int K7        = 2,
  parameter int K8        = 1,
  parameter int SHIFT     = 4,
  parameter int FRAME_PIX = 65536
) (
  input  logic         clk,
  input  logic         reset,
  conv3x3_mac_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, NORM} state_t;

  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PW) - 1);
  localparam logic [15:0]             CNT_LAST = 16'(FRAME_PIX - 1);

  state_t                   state_q, state_d;
  logic [PW-1:0]            pix_q [9];
  logic [PW-1:0]            pix_d [9];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]               idx_q, idx_d;
  logic [PW-1:0]            pix_out_q, pix_out_d;
  logic                     done_q, done_d;
  logic                     frame_done_q, frame_done_d;
  logic [15:0]              pix_count_q, pix_count_d;

  logic signed [CW-1:0]     coef;
  logic [PW-1:0]            pix_sel;
  logic signed [PW:0]       pix_ext;
  logic signed [ACC_W-1:0]  prod;
  logic [PW-1:0]            norm_pix;

  // Select the current tap's coefficient and pixel and form the signed product
  always_comb begin
    coef    = '0;
    pix_sel = '0;
    case (idx_q)
      4'd0: begin coef = CW'(K0); pix_sel = pix_q[0]; end
      4'd1: begin coef = CW'(K1); pix_sel = pix_q[1]; end
      4'd2: begin coef = CW'(K2); pix_sel = pix_q[2]; end
      4'd3: begin coef = CW'(K3); pix_sel = pix_q[3]; end
      4'd4: begin coef = CW'(K4); pix_sel = pix_q[4]; end
      4'd5: begin coef = CW'(K5); pix_sel = pix_q[5]; end
      4'd6: begin coef = CW'(K6); pix_sel = pix_q[6]; end
      4'd7: begin coef = CW'(K7); pix_sel = pix_q[7]; end
      4'd8: begin coef = CW'(K8); pix_sel = pix_q[8]; end
      default: ;
    endcase
    // pixels are unsigned, so a zero MSB keeps them positive in the signed product
    pix_ext = {1'b0, pix_sel};
    prod    = ACC_W'(pix_ext) * ACC_W'(coef);
  end

`ifdef CONV_ABS_OUT_EN
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] shr;

  // Magnitude, shift, saturate at the top of the pixel range
  always_comb begin
    mag      = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : acc_q;
    shr      = mag >> SHIFT;
    norm_pix = (shr > PIX_MAX) ? PIX_MAX[PW-1:0] : shr[PW-1:0];
  end
`else
  logic signed [ACC_W-1:0] shr;

  // Arithmetic (floor) shift, then clamp to [0, 2^PW-1]
  always_comb begin
    shr = acc_q >>> SHIFT;
    if (shr[ACC_W-1]) begin
      norm_pix = '0;
    end else if (shr > PIX_MAX) begin
      norm_pix = PIX_MAX[PW-1:0];
    end else begin
      norm_pix = shr[PW-1:0];
    end
  end
`endif

  // Next-state and datapath updates for IDLE / MAC / NORM
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    pix_out_d    = pix_out_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pix_d[0] = bus.m1d1;
          pix_d[1] = bus.m1d2;
          pix_d[2] = bus.m1d3;
          pix_d[3] = bus.m2d1;
          pix_d[4] = bus.m2d2;
          pix_d[5] = bus.m2d3;
          pix_d[6] = bus.m3d1;
          pix_d[7] = bus.m3d2;
          pix_d[8] = bus.m3d3;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd8) begin
          state_d = NORM;
        end
      end
      NORM: begin
        pix_out_d = norm_pix;
        done_d    = 1'b1;
        if (pix_count_q == CNT_LAST) begin
          pix_count_d  = '0;
          frame_done_d = 1'b1;
        end else begin
          pix_count_d = pix_count_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pix_q        <= '{default: '0};
      acc_q        <= '0;
      idx_q        <= '0;
      pix_out_q    <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      pix_out_q    <= pix_out_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.pix_out    = pix_out_q;
  assign bus.done       = done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pix_count  = pix_count_q;

endmodule
